// File: rtl/instr_decode.sv
// instr_decode: consumer end of the instruction-fetch stream.
// Buffers pushed instructions in a FIFO, decodes them one at a time and
// dispatches LOAD / CONV commands over valid/ready handshakes.
module instr_decode #(
  parameter int FIFO_DEPTH = 16,
  parameter int INSTR_W    = 64,
  parameter int TAG_W      = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INSTR_W-1:0]            i_instr,
  input  logic [TAG_W-1:0]              i_instr_addr,
  input  logic                          i_instr_enable,
  output logic [7:0]                    o_cmd_ftype,
  output logic [15:0]                   o_cmd_saddr,
  output logic [15:0]                   o_cmd_daddr,
  output logic [7:0]                    o_cmd_memsel,
  output logic [TAG_W-1:0]              o_cmd_tag,
  output logic                          o_ld_valid,
  input  logic                          i_ld_ready,
  input  logic                          i_ld_idle,
  output logic                          o_conv_valid,
  input  logic                          i_conv_ready,
  input  logic                          i_conv_done,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_err_illegal,
  output logic                          o_err_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // Reserved low byte is never stored
  localparam int EW = TAG_W + INSTR_W - 8;

  localparam logic [7:0] OP_LOAD = 8'h04;
  localparam logic [7:0] OP_CONV = 8'h81;
  localparam logic [7:0] OP_NOP  = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_LD_ISSUE,
    S_CONV_WAIT,
    S_CONV_ISSUE,
    S_CONV_RUN
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [EW-1:0]  head;
  logic           pop, full, push_ok;
  logic [7:0]     cur_op;
  logic           op_illegal;
  logic           unused_rsvd;

  assign unused_rsvd = ^i_instr[7:0];

  assign head       = mem[rd_ptr];
  assign pop        = (state == S_IDLE) && (count != '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok    = i_instr_enable && (!full || pop);
  assign op_illegal = (cur_op != OP_LOAD) && (cur_op != OP_CONV) && (cur_op != OP_NOP);
  assign o_fifo_count = count;

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {tag, instr[63:8]}
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {i_instr_addr, i_instr[INSTR_W-1:8]};
  end

  // Current-instruction register; loaded on the pop that enters DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_op       <= '0;
      o_cmd_ftype  <= '0;
      o_cmd_saddr  <= '0;
      o_cmd_daddr  <= '0;
      o_cmd_memsel <= '0;
      o_cmd_tag    <= '0;
    end else if (pop) begin
      cur_op       <= head[EW-TAG_W-1 -: 8];
      o_cmd_ftype  <= head[EW-TAG_W-9 -: 8];
      o_cmd_saddr  <= head[EW-TAG_W-17 -: 16];
      o_cmd_daddr  <= head[EW-TAG_W-33 -: 16];
      o_cmd_memsel <= head[7:0];
      o_cmd_tag    <= head[EW-1 -: TAG_W];
    end
  end

  // Sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err_illegal  <= 1'b0;
      o_err_overflow <= 1'b0;
    end else begin
      if (state == S_DECODE && op_illegal) o_err_illegal  <= 1'b1;
      if (i_instr_enable && !push_ok)      o_err_overflow <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (pop) state_nxt = S_DECODE;
      S_DECODE: begin
        if (cur_op == OP_LOAD)      state_nxt = S_LD_ISSUE;
        else if (cur_op == OP_CONV) state_nxt = S_CONV_WAIT;
        else                        state_nxt = S_IDLE;
      end
      S_LD_ISSUE:   if (i_ld_ready)   state_nxt = S_IDLE;
      S_CONV_WAIT:  if (i_ld_idle)    state_nxt = S_CONV_ISSUE;
      S_CONV_ISSUE: if (i_conv_ready) state_nxt = S_CONV_RUN;
      S_CONV_RUN:   if (i_conv_done)  state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_ld_valid   = (state == S_LD_ISSUE);
    o_conv_valid = (state == S_CONV_ISSUE);
    o_busy       = (state != S_IDLE) || (count != '0);
  end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Consumer end of the instruction-fetch stream.
- Accepts 64-bit instructions pushed by the fetch stage (`i_instr`, `i_instr_addr`, `i_instr_enable`; no backpressure) and buffers them in an internal FIFO.
- Decodes one instruction at a time and dispatches LOAD commands to the feature/weight loader and CONV commands to the conv engine over valid/ready handshakes.
- Serialises CONV behind outstanding loads and flags illegal opcodes and overflow.

Parameters:
- FIFO_DEPTH, 16, instruction buffer entries (power of 2, ≥2)
- INSTR_W, 64, instruction width
- TAG_W, 5, width of instruction address/tag

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_instr  in  64  instruction word from fetch stage
- i_instr_addr  in  5  instruction index, carried as tag
- i_instr_enable  in  1  push strobe, one instruction per cycle when high
- o_cmd_ftype  out  8  instr[55:48]
- o_cmd_saddr  out  16  instr[47:32]
- o_cmd_daddr  out  16  instr[31:16]
- o_cmd_memsel  out  8  instr[15:8]
- o_cmd_tag  out  5  tag of current command
- o_ld_valid  out  1  LOAD command valid
- i_ld_ready  in  1  loader accepts
- i_ld_idle  in  1  loader has no outstanding transfers
- o_conv_valid  out  1  CONV command valid
- i_conv_ready  in  1  conv engine accepts
- i_conv_done  in  1  one-cycle pulse, conv finished
- o_busy  out  1  state != IDLE or FIFO non-empty
- o_fifo_count  out  5  FIFO occupancy, 0..16
- o_err_illegal  out  1  sticky, illegal opcode seen
- o_err_overflow  out  1  sticky, push dropped on full FIFO

Behaviour:
- Field map: opcode = instr[63:56]; instr[7:0] reserved, ignored.
- Opcode classes:
  - 0x04 = LOAD
  - 0x81 = CONV
  - 0x00 = NOP
  - anything else = illegal
- Reset:
  - All outputs 0; FIFO pointers and count 0; state IDLE.
  - Sticky errors cleared.
  - Reset mid-handshake drops the current command with no completion.
- FIFO:
  - Push on `i_instr_enable` stores {tag, instr}.
  - Push is accepted when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the push is dropped and `o_err_overflow` is set to 1.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - `o_fifo_count` is registered and updates the cycle after the event.
- FSM states and transitions:
  - IDLE: if count > 0, pop the head into the current-instruction register and go to DECODE. Earliest pop is the cycle after the push edge.
  - DECODE (1 cycle):
    - LOAD → LD_ISSUE
    - CONV → CONV_WAIT
    - NOP → IDLE, no output
    - illegal → set `o_err_illegal`, go to IDLE, instruction discarded
  - LD_ISSUE: `o_ld_valid` = 1; `o_cmd_*` held stable. On `o_ld_valid` && `i_ld_ready` → IDLE; `o_ld_valid` deasserts the following cycle.
  - CONV_WAIT: wait for `i_ld_idle` = 1, then → CONV_ISSUE.
  - CONV_ISSUE: `o_conv_valid` = 1, fields stable. On handshake → CONV_RUN.
  - CONV_RUN: wait for `i_conv_done`, then → IDLE. A `i_conv_done` pulse in any other state is ignored.
- Latency: a push into an empty FIFO while IDLE gives valid asserted 3 cycles after the push edge (pop, decode, issue).
- Outputs:
  - `o_cmd_*` fields are registered and change only on entry to DECODE.
  - `o_ld_valid` and `o_conv_valid` are never high simultaneously.
  - Pushes continue to be accepted in every state.

Test Plan:
- Push 0x0400000100010100, tag 1, into an empty FIFO; `i_ld_ready` = 1. → `o_ld_valid` high 3 cycles after the push for 1 cycle with ftype = 0x00, saddr = 0x0001, daddr = 0x0001, memsel = 0x01, tag = 1. `o_busy` returns to 0.
- Push 5 LOADs back-to-back; hold `i_ld_ready` = 0 for 20 cycles, then 1. → Valid is held with stable fields. Commands issue in tag order 0..4, each handshake followed by 2 cycles (pop, decode) before the next valid. `o_fifo_count` peaks at 4.
- Push LOAD then CONV 0x8100000400040100; keep `i_ld_idle` = 0 for 10 cycles after the load handshake. → `o_conv_valid` stays 0 until `i_ld_idle` = 1. The next instruction is not popped until the `i_conv_done` pulse.
- Push opcode 0x55 then NOP then LOAD. → `o_err_illegal` = 1 and stays set. No valid is issued for 0x55 or the NOP. The LOAD dispatches normally.
- Stall the loader and push 18 instructions. → `o_fifo_count` = 16, `o_err_overflow` = 1, and the 18th push is dropped. Pushing on the cycle the stall releases and a pop occurs is accepted.
- Assert `rst` during LD_ISSUE with 3 entries queued. → The next cycle shows all outputs 0, count 0, errors cleared, state IDLE.
